// File: rtl/shift_counter_pkg.sv
// Shared constants and helpers for the Johnson/ring shift counter.
// Imported by the decoder and the top level.
package shift_counter_pkg;

  localparam int MODE_JOHNSON = 0;
  localparam int MODE_RING    = 1;

  // Ring counters park on bit 0; Johnson counters park on all-zero.
  function automatic logic [31:0] reset_value(int mode, int width);
    logic [31:0] v;
    v = '0;
    if (mode == MODE_RING && width > 0) v[0] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational legality check and phase index for one state vector.
// Used on both the load value and the live count.
module shift_counter_decode
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON,
  localparam int PW   = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] state_i,
  output logic             legal_o,
  output logic [PW-1:0]    phase_o
);

  logic [WIDTH-1:0] th;
  int               pop;

  // Classify the pattern and derive its index in the sequence.
  always_comb begin
    legal_o = 1'b0;
    phase_o = '0;
    th      = '0;
    pop     = 0;
    if (MODE == MODE_RING) begin
      legal_o = $onehot(state_i);
      for (int i = 0; i < WIDTH; i++)
        if (state_i[i]) phase_o = PW'(i);
    end else begin
      for (int k = 0; k <= WIDTH; k++) begin
        if (state_i == th || state_i == ~th) legal_o = 1'b1;
        th = {th[WIDTH-2:0], 1'b1};
      end
      for (int i = 0; i < WIDTH; i++)
        pop = pop + int'(state_i[i]);
      if (state_i[WIDTH-1]) phase_o = PW'(2 * WIDTH - pop);
      else                  phase_o = PW'(pop);
    end
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Parametrised Johnson / ring shift counter with load, direction,
// legality checking, self-correction and a registered phase index.
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON,
  localparam int PW   = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             err
);

  localparam int N = (MODE == MODE_RING) ? WIDTH : 2 * WIDTH;
  localparam logic [WIDTH-1:0] RST  = WIDTH'(reset_value(MODE, WIDTH));
  localparam logic [PW-1:0]    LAST = PW'(N - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             ld_legal, cur_legal;
  logic [PW-1:0]    ld_phase, cur_phase;

  shift_counter_decode #(.WIDTH(WIDTH), .MODE(MODE)) u_ld_dec (
    .state_i (load_val),
    .legal_o (ld_legal),
    .phase_o (ld_phase)
  );

  shift_counter_decode #(.WIDTH(WIDTH), .MODE(MODE)) u_cur_dec (
    .state_i (count_q),
    .legal_o (cur_legal),
    .phase_o (cur_phase)
  );

  // Next-state mux: load, then recovery from an illegal state, then step.
  always_comb begin
    count_d = count_q;
    phase_d = cur_phase;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (ld_legal) begin
        count_d = load_val;
        phase_d = ld_phase;
      end else begin
        count_d = RST;
        phase_d = '0;
        err_d   = 1'b1;
      end
    end else if (!cur_legal) begin
      count_d = RST;
      phase_d = '0;
      err_d   = 1'b1;
    end else if (en) begin
      if (!dir) begin
        if (MODE == MODE_RING)
          count_d = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
        else
          count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        phase_d = (cur_phase == LAST) ? '0 : cur_phase + 1'b1;
        wrap_d  = (cur_phase == LAST);
      end else begin
        if (MODE == MODE_RING)
          count_d = {count_q[0], count_q[WIDTH-1:1]};
        else
          count_d = {~count_q[0], count_q[WIDTH-1:1]};
        phase_d = (cur_phase == '0) ? LAST : cur_phase - 1'b1;
        wrap_d  = (cur_phase == '0);
      end
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Scoreboard bench for shift_counter_gen, one Johnson and one ring
// instance at WIDTH=4 driven from shared stimulus.
module tb_shift_counter_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, dir, load;
  logic [3:0] load_val;

  logic [3:0] j_count, r_count;
  logic [2:0] j_phase, r_phase;
  logic       j_wrap, r_wrap, j_err, r_err;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    string      tag;
    logic       ring;
    logic [3:0] c;
    logic [2:0] p;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_counter_gen #(.WIDTH(4), .MODE(0)) u_j (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .count(j_count), .phase(j_phase),
    .wrap(j_wrap), .err(j_err)
  );

  shift_counter_gen #(.WIDTH(4), .MODE(1)) u_r (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
    .load_val(load_val), .count(r_count), .phase(r_phase),
    .wrap(r_wrap), .err(r_err)
  );

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the negedge, push the expectation, then compare
  // the registered outputs just after the rising edge.
  task automatic cyc(string tag, logic ring, logic e_en, logic e_dir,
                     logic e_ld, logic [3:0] lv, logic [3:0] c,
                     logic [2:0] p, logic w, logic e);
    exp_t x;
    en = e_en; dir = e_dir; load = e_ld; load_val = lv;
    sb.push_back('{tag, ring, c, p, w, e});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
    end else begin
      x = sb.pop_front();
      if (x.ring) begin
        check_eq({x.tag, "_count"}, 32'(r_count), 32'(x.c));
        check_eq({x.tag, "_phase"}, 32'(r_phase), 32'(x.p));
        check_eq({x.tag, "_wrap"},  32'(r_wrap),  32'(x.w));
        check_eq({x.tag, "_err"},   32'(r_err),   32'(x.e));
      end else begin
        check_eq({x.tag, "_count"}, 32'(j_count), 32'(x.c));
        check_eq({x.tag, "_phase"}, 32'(j_phase), 32'(x.p));
        check_eq({x.tag, "_wrap"},  32'(j_wrap),  32'(x.w));
        check_eq({x.tag, "_err"},   32'(j_err),   32'(x.e));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    #12;
    check_eq("rst_j_count", 32'(j_count), 0);
    check_eq("rst_j_phase", 32'(j_phase), 0);
    check_eq("rst_j_wrap",  32'(j_wrap),  0);
    check_eq("rst_j_err",   32'(j_err),   0);
    check_eq("rst_r_count", 32'(r_count), 1);
    check_eq("rst_r_phase", 32'(r_phase), 0);
    @(negedge clk);
    reset = 1'b0;

    cyc("jf1", 0, 1, 0, 0, 4'h0, 4'b0001, 3'd1, 0, 0);
    cyc("jf2", 0, 1, 0, 0, 4'h0, 4'b0011, 3'd2, 0, 0);
    cyc("jf3", 0, 1, 0, 0, 4'h0, 4'b0111, 3'd3, 0, 0);
    cyc("jf4", 0, 1, 0, 0, 4'h0, 4'b1111, 3'd4, 0, 0);
    cyc("jf5", 0, 1, 0, 0, 4'h0, 4'b1110, 3'd5, 0, 0);
    cyc("jf6", 0, 1, 0, 0, 4'h0, 4'b1100, 3'd6, 0, 0);
    cyc("jf7", 0, 1, 0, 0, 4'h0, 4'b1000, 3'd7, 0, 0);
    cyc("jf8", 0, 1, 0, 0, 4'h0, 4'b0000, 3'd0, 1, 0);

    cyc("jr1", 0, 1, 1, 0, 4'h0, 4'b1000, 3'd7, 1, 0);
    cyc("jr2", 0, 1, 1, 0, 4'h0, 4'b1100, 3'd6, 0, 0);
    cyc("jr3", 0, 1, 1, 0, 4'h0, 4'b1110, 3'd5, 0, 0);
    cyc("jr4", 0, 1, 1, 0, 4'h0, 4'b1111, 3'd4, 0, 0);
    cyc("jr5", 0, 1, 1, 0, 4'h0, 4'b0111, 3'd3, 0, 0);

    for (int i = 0; i < 3; i++)
      cyc("jhold", 0, 0, 0, 0, 4'h0, 4'b0111, 3'd3, 0, 0);

    cyc("jld_a", 0, 1, 0, 1, 4'b0011, 4'b0011, 3'd2, 0, 0);
    cyc("jld_b", 0, 1, 0, 1, 4'b0111, 4'b0111, 3'd3, 0, 0);

    cyc("jdir1", 0, 1, 0, 0, 4'h0, 4'b1111, 3'd4, 0, 0);
    cyc("jdir2", 0, 1, 1, 0, 4'h0, 4'b0111, 3'd3, 0, 0);
    cyc("jdir3", 0, 1, 1, 0, 4'h0, 4'b0011, 3'd2, 0, 0);
    cyc("jdir4", 0, 1, 0, 0, 4'h0, 4'b0111, 3'd3, 0, 0);

    cyc("jld_c", 0, 0, 0, 1, 4'b1100, 4'b1100, 3'd6, 0, 0);
    cyc("jill",  0, 1, 0, 1, 4'b0101, 4'b0000, 3'd0, 0, 1);
    cyc("jpost", 0, 0, 0, 0, 4'h0,    4'b0000, 3'd0, 0, 0);

    cyc("jld_d", 0, 0, 0, 1, 4'b0111, 4'b0111, 3'd3, 0, 0);
    en = 1'b1; load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_count", 32'(j_count), 0);
    check_eq("arst_phase", 32'(j_phase), 0);
    check_eq("arst_wrap",  32'(j_wrap),  0);
    check_eq("arst_err",   32'(j_err),   0);
    @(negedge clk);
    reset = 1'b0;
    cyc("jrel", 0, 1, 0, 0, 4'h0, 4'b0001, 3'd1, 0, 0);

    #2 reset = 1'b1;
    #1;
    check_eq("rrst_count", 32'(r_count), 1);
    check_eq("rrst_phase", 32'(r_phase), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc("rf1", 1, 1, 0, 0, 4'h0, 4'b0010, 3'd1, 0, 0);
    cyc("rf2", 1, 1, 0, 0, 4'h0, 4'b0100, 3'd2, 0, 0);
    cyc("rf3", 1, 1, 0, 0, 4'h0, 4'b1000, 3'd3, 0, 0);
    cyc("rf4", 1, 1, 0, 0, 4'h0, 4'b0001, 3'd0, 1, 0);
    cyc("rill", 1, 1, 0, 1, 4'b0011, 4'b0001, 3'd0, 0, 1);
    cyc("rzero", 1, 0, 0, 1, 4'b0000, 4'b0001, 3'd0, 0, 1);
    cyc("rld", 1, 0, 0, 1, 4'b0100, 4'b0100, 3'd2, 0, 0);
    cyc("rr1", 1, 1, 1, 0, 4'h0, 4'b0010, 3'd1, 0, 0);
    cyc("rr2", 1, 1, 1, 0, 4'h0, 4'b0001, 3'd0, 0, 0);
    cyc("rr3", 1, 1, 1, 0, 4'h0, 4'b1000, 3'd3, 1, 0);

    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
Parametrised twisted-ring (Johnson) / ring shift counter. It is the successor of the fixed 4-bit twisted ring counter and adds width, mode, direction, enable, parallel load, legality checking and a decoded phase index. It serves as a phase/sequence generator for timing and strobe logic elsewhere in the design.

Parameters:
- WIDTH, 4, number of counter bits; legal range 2..32.
- MODE, 0, 0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states).
- PW, $clog2(2*WIDTH), localparam (derived); phase index width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance one state this cycle
- dir  in  1  0 = forward (shift toward MSB), 1 = reverse
- load  in  1  parallel load of load_val; has priority over en
- load_val  in  WIDTH  value to load
- count  out  WIDTH  counter state
- phase  out  PW  index of the current state in the sequence
- wrap  out  1  one-cycle pulse when the sequence crosses the index boundary
- err  out  1  one-cycle pulse when an illegal load was rejected

Behaviour:
- Reset (async, while reset=1):
  - Johnson: count = 0.
  - Ring: count = 1 (bit 0 set).
  - phase = 0, wrap = 0, err = 0.
  - Outputs change immediately on reset assertion, not at the next clock edge.
- All outputs are registered. phase is always consistent with count in the same cycle, i.e. computed from the next-state value.
- Next state, highest priority first:
  - load=1, load_val legal: count <= load_val; wrap = 0; err = 0.
  - load=1, load_val illegal: count <= reset value; err = 1 for one cycle; wrap = 0.
  - en=1, dir=0, Johnson: count <= {count[W-2:0], ~count[W-1]}.
  - en=1, dir=0, ring: count <= {count[W-2:0], count[W-1]}.
  - en=1, dir=1, Johnson: count <= {~count[0], count[W-1:1]}.
  - en=1, dir=1, ring: count <= {count[0], count[W-1:1]}.
  - otherwise: hold; wrap = 0; err = 0.
- Legal states:
  - Johnson: 2*WIDTH thermometer patterns reachable from 0, i.e. a contiguous run of ones anchored at bit 0, or the complement of such a run.
  - Ring: exactly one bit set.
- Phase index:
  - Johnson: if count[W-1] = 0, phase = popcount(count); otherwise phase = 2*WIDTH - popcount(count). W=4: 0000=0, 0111=3, 1111=4, 1000=7.
  - Ring: phase = bit position of the set bit.
- wrap = 1 for the cycle after an en step from the last index to 0 (forward) or from 0 to the last index (reverse). Never asserted on load or reset.
- Self-correction: if the registered count is ever illegal (e.g. an SEU), the next en step or hold forces the reset value and pulses err. The block therefore always recovers within one cycle.
- Single-cycle latency from load/en to count/phase/wrap/err.
- dir may change on any cycle; a reversal takes effect on the next step, with no extra delay.

Decomposition:
- Package shift_counter_pkg holds:
  - MODE_JOHNSON = 0 and MODE_RING = 1.
  - Function reset_value(mode, width).
- Sub-module shift_counter_decode (combinational, parameters WIDTH and MODE):
  - Input: state vector.
  - Outputs: legal (1 bit) and phase (PW bits).
  - Instantiated twice: once on load_val for legality, once on the current count for the self-correction check.
- The top level holds the next-state mux and the registers.

Test Plan:
- Johnson, W=4, reset then en=1, dir=0 for 8 cycles:
  - count sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
  - phase 1..7 then 0.
  - wrap high only on the cycle count returns to 0000.
- Johnson from 0000, en=1, dir=1:
  - count 1000, 1100, 1110, 1111, 0111.
  - phase 7, 6, 5, 4, 3.
  - wrap high on the first step only.
- Load behaviour:
  - en=0 for 3 cycles: count holds.
  - load=1, en=1, load_val=0111: count=0111, phase=3, wrap=0 (load wins over en).
  - dir toggled mid-stream: the sequence reverses on the next step.
- Illegal load load_val=0101 while count=1100: next cycle count=0000, phase=0, err=1 for exactly one cycle, wrap=0.
- Ring, MODE=1, W=4:
  - Reset: count=0001.
  - Forward: 0010, 0100, 1000, 0001, with wrap on 0001.
  - Illegal load 0011: count=0001, err=1.
  - Load of 0000: err=1.
- Async reset mid-count:
  - Assert reset between clock edges at count=0111: count=0000, phase=0, wrap=0, err=0 before the next edge.
  - Release reset with en=1: first step to 0001 on the first edge after release.
